// File: rtl/imem_program_loader.sv
// Instruction memory loader: takes a LEN/DATA/SUM framed byte stream and
// writes it into the fetch-side instruction RAM, holding the CPU until clean.
module imem_program_loader #(
   parameter int ADDR_W  = 6,
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 1023
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]     TMO_ONE  = TW'(1);
   localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_SUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [7:0]        sum_q, sum_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              active;
   logic              accept;

   assign active = (state_q == S_LEN) || (state_q == S_DATA) ||
                   (state_q == S_SUM);
   assign accept = in_valid & active;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      tmo_d   = '0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN;
               cnt_d   = '0;
               sum_d   = '0;
            end
         end
         S_LEN: begin
            if (accept) begin
               if (in_data == 8'd0 || int'(in_data) > DEPTH) begin
                  state_d = S_ERR;
               end else begin
                  len_d   = (ADDR_W + 1)'(in_data);
                  cnt_d   = '0;
                  sum_d   = '0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = cnt_q;
               wdata_d = in_data;
               sum_d   = sum_q + in_data;
               cnt_d   = cnt_q + CNT_ONE;
               if ({1'b0, cnt_q} + LEN_ONE == len_q) begin
                  state_d = S_SUM;
               end
            end
         end
         S_SUM: begin
            if (accept) begin
               state_d = (in_data == sum_q) ? S_DONE : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Inter-byte watchdog; only runs while a frame is open
      if (active && !accept) begin
         if (tmo_q == TMO_LAST) begin
            state_d = S_ERR;
         end else begin
            tmo_d = tmo_q + TMO_ONE;
         end
      end
      hold_d = (state_d != S_DONE);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         tmo_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = active;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_hold  = hold_q;
   assign load_done = done_q;
   assign load_err  = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: table vectors, spec sequences and random
// frames checked against a frame-level reference model.
module tb_imem_program_loader;

   localparam int ADDR_W  = 6;
   localparam int DEPTH   = 64;
   localparam int TIMEOUT = 1023;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;

   imem_program_loader #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold (cpu_hold),
      .load_done(load_done),
      .load_err (load_err)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         failures = 0;
   bit         exp_we = 1'b0;
   int         exp_addr = 0;
   logic [7:0] exp_data = 8'd0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      chk("mem_we", int'(mem_we), int'(exp_we));
      if (exp_we && mem_we) begin
         chk("mem_addr", int'(mem_addr), exp_addr);
         chk("mem_wdata", int'(mem_wdata), int'(exp_data));
      end
      exp_we = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap,
                            input bit wr, input int addr,
                            input bit start_mid);
      bit acc;
      int guard;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         start = start_mid && (g == 0);
         step();
         start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = b;
      acc      = 1'b0;
      guard    = 0;
      while (!acc && guard < 20) begin
         acc      = in_ready;
         exp_we   = acc && wr;
         exp_addr = addr;
         exp_data = b;
         step();
         guard++;
      end
      if (!acc) chk("accept_bound", 0, 1);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_hold", int'(cpu_hold), 1);
      chk("start_done", int'(load_done), 0);
      chk("start_err", int'(load_err), 0);
      chk("start_ready", int'(in_ready), 1);
   endtask

   task automatic check_end(input bit d, input bit e);
      chk("end_done", int'(load_done), int'(d));
      chk("end_err", int'(load_err), int'(e));
      chk("end_hold", int'(cpu_hold), int'(!d));
      chk("end_ready", int'(in_ready), 0);
   endtask

   function automatic int gap_of(input int maxgap);
      return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
   endfunction

   // Reference: a frame's fate follows from LEN range and the mod-256 sum
   task automatic run_frame(input logic [7:0] len, input logic [7:0] data[$],
                            input logic [7:0] sb, input int maxgap,
                            output bit d, output bit e);
      logic [7:0] s;
      do_start();
      send_byte(len, gap_of(maxgap), 1'b0, 0, 1'b0);
      if (len == 8'd0 || int'(len) > DEPTH) begin
         d = 1'b0;
         e = 1'b1;
      end else begin
         s = 8'd0;
         for (int i = 0; i < int'(len); i++) begin
            send_byte(data[i], gap_of(maxgap), 1'b1, i, 1'b0);
            s = s + data[i];
         end
         send_byte(sb, gap_of(maxgap), 1'b0, 0, 1'b0);
         d = (sb == s);
         e = !d;
      end
      check_end(d, e);
   endtask

   typedef struct {
      logic [7:0] len;
      logic [7:0] delta;
      bit         ed;
      bit         ee;
   } vec_t;

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t       vt[6];
      logic [7:0] q[$];
      logic [7:0] s;
      logic [7:0] len;
      bit         d, e;
      int         r;

      vt[0] = '{8'd1,   8'd0, 1'b1, 1'b0};
      vt[1] = '{8'd64,  8'd0, 1'b1, 1'b0};
      vt[2] = '{8'd7,   8'd1, 1'b0, 1'b1};
      vt[3] = '{8'd0,   8'd0, 1'b0, 1'b1};
      vt[4] = '{8'd65,  8'd0, 1'b0, 1'b1};
      vt[5] = '{8'd200, 8'd0, 1'b0, 1'b1};

      reset = 1'b1;
      step();
      step();
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_addr", int'(mem_addr), 0);
      chk("rst_wdata", int'(mem_wdata), 0);
      chk("rst_hold", int'(cpu_hold), 1);
      chk("rst_done", int'(load_done), 0);
      chk("rst_err", int'(load_err), 0);
      reset = 1'b0;
      step();
      chk("idle_ready", int'(in_ready), 0);

      // Spec frame: 03 41 82 C0 83
      q = '{8'h41, 8'h82, 8'hC0};
      run_frame(8'h03, q, 8'h83, 0, d, e);
      chk("t1_done", int'(load_done), 1);
      chk("t1_hold", int'(cpu_hold), 0);

      // Bad checksum, then a clean reload
      q = '{8'h10, 8'h20};
      run_frame(8'h02, q, 8'hFF, 0, d, e);
      chk("t2_err", int'(load_err), 1);
      chk("t2_hold", int'(cpu_hold), 1);
      run_frame(8'h02, q, 8'h30, 1, d, e);
      chk("t2_redo", int'(load_done), 1);

      // LEN out of range
      run_frame(8'h00, q, 8'h00, 0, d, e);
      chk("t3_len0", int'(load_err), 1);
      run_frame(8'h41, q, 8'h00, 0, d, e);
      chk("t3_len65", int'(load_err), 1);

      // Full memory with random valid gaps
      q = {};
      for (int i = 0; i < DEPTH; i++) q.push_back(8'(i));
      run_frame(8'h40, q, 8'hE0, 3, d, e);
      chk("t4_done", int'(load_done), 1);

      for (int v = 0; v < 6; v++) begin
         q = {};
         s = 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            q.push_back(8'(i * 5 + 1));
            if (i < int'(vt[v].len)) s = s + 8'(i * 5 + 1);
         end
         run_frame(vt[v].len, q, s + vt[v].delta, 2, d, e);
         chk("vec_done", int'(load_done), int'(vt[v].ed));
         chk("vec_err", int'(load_err), int'(vt[v].ee));
      end

      // Timeout mid-data, with an ignored start inside the idle stretch
      do_start();
      send_byte(8'h05, 0, 1'b0, 0, 1'b0);
      send_byte(8'h11, 0, 1'b1, 0, 1'b0);
      send_byte(8'h22, 0, 1'b1, 1, 1'b0);
      for (int k = 1; k < TIMEOUT; k++) begin
         start = (k == 100);
         step();
         start = 1'b0;
      end
      chk("t5_pre_err", int'(load_err), 0);
      chk("t5_pre_ready", int'(in_ready), 1);
      step();
      chk("t5_err", int'(load_err), 1);
      chk("t5_hold", int'(cpu_hold), 1);
      chk("t5_done", int'(load_done), 0);
      chk("t5_ready", int'(in_ready), 0);

      // Reset in the middle of the data phase
      do_start();
      send_byte(8'h04, 0, 1'b0, 0, 1'b0);
      send_byte(8'h5A, 0, 1'b1, 0, 1'b0);
      send_byte(8'hA5, 0, 1'b1, 1, 1'b0);
      reset = 1'b1;
      step();
      chk("t6_ready", int'(in_ready), 0);
      chk("t6_addr", int'(mem_addr), 0);
      chk("t6_wdata", int'(mem_wdata), 0);
      chk("t6_hold", int'(cpu_hold), 1);
      chk("t6_done", int'(load_done), 0);
      chk("t6_err", int'(load_err), 0);
      reset = 1'b0;
      step();
      chk("t6_idle", int'(in_ready), 0);
      q = '{8'h01, 8'h02};
      run_frame(8'h02, q, 8'h03, 1, d, e);
      chk("t6_recover", int'(load_done), 1);

      // Random frames
      for (int f = 0; f < 40; f++) begin
         r = int'($urandom_range(19, 0));
         if (r == 0) len = 8'd0;
         else if (r == 1) len = 8'($urandom_range(255, DEPTH + 1));
         else len = 8'($urandom_range(DEPTH, 1));
         q = {};
         s = 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            q.push_back(8'($urandom));
            if (i < int'(len)) s = s + q[i];
         end
         if ($urandom_range(3, 0) == 0) s = s + 8'($urandom_range(255, 1));
         run_frame(len, q, s, 2, d, e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
